// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter: shares the single regfile write port between the in-order
// write-back stage and a FIFO-buffered long-latency unit, and exports a
// scoreboard of long-op destinations still waiting to be written.
// Optional feature macro: RF_ARB_STARVE_GUARD_EN (starvation counter + forced drain).
module rf_wport_arbiter #(
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ws_rf_we,
  input  logic [4:0]  ws_rf_waddr,
  input  logic [31:0] ws_rf_wdata,
  output logic        ws_stall,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_waddr,
  input  logic [31:0] lu_wdata,
  input  logic        lu_issue,
  input  logic [4:0]  lu_issue_dest,
  output logic [31:0] sb_busy,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

  logic [4:0]      fifo_addr_q [FIFO_DEPTH];
  logic [31:0]     fifo_data_q [FIFO_DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     sb_q, sb_d;
  logic            fifo_nonempty, push, pop, fifo_win, starve_hit;
  logic [4:0]      head_addr;
  logic [31:0]     head_data;

  assign fifo_nonempty = (count_q != '0);
  assign head_addr     = fifo_addr_q[rd_ptr_q];
  assign head_data     = fifo_data_q[rd_ptr_q];
  // Credit comes from the registered count only; a same-cycle pop frees nothing.
  assign lu_ready      = resetn && (count_q < DepthCnt);
  assign push          = lu_valid && lu_ready;
  assign fifo_win      = fifo_nonempty && (!ws_rf_we || starve_hit);
  assign pop           = fifo_win;
  assign sb_busy       = sb_q;

`ifdef RF_ARB_STARVE_GUARD_EN
  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt_q, starve_cnt_d;

  assign starve_hit = (starve_cnt_q == StarveMax);

  // Count write-back wins while the FIFO waits; any FIFO grant or an empty FIFO clears it.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!fifo_nonempty || fifo_win) begin
      starve_cnt_d = '0;
    end else if (ws_rf_we) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  // Without the guard the FIFO only drains in write-back bubbles.
  assign starve_hit = 1'b0;
`endif

  // Grant mux: the FIFO head overrides write-back when it wins; r0 never writes.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = ws_rf_waddr;
    rf_wdata = ws_rf_wdata;
    ws_stall = 1'b0;
    if (fifo_win) begin
      rf_waddr = head_addr;
      rf_wdata = head_data;
      rf_we    = (head_addr != 5'd0);
      // A FIFO win against an active write-back only happens on a forced drain.
      ws_stall = ws_rf_we;
    end else begin
      rf_we = ws_rf_we && (ws_rf_waddr != 5'd0);
    end
    if (!resetn) begin
      rf_we    = 1'b0;
      ws_stall = 1'b0;
    end
  end

  // FIFO occupancy next state.
  always_comb begin
    count_d = count_q + CntW'(push) - CntW'(pop);
  end

  // Scoreboard next state; a same-cycle issue wins over the pop clear.
  always_comb begin
    sb_d = sb_q;
    if (pop) begin
      sb_d[head_addr] = 1'b0;
    end
    if (lu_issue && (lu_issue_dest != 5'd0)) begin
      sb_d[lu_issue_dest] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  // FIFO pointers, occupancy and scoreboard registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      sb_q     <= '0;
    end else begin
      count_q <= count_d;
      sb_q    <= sb_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  // FIFO storage; contents are meaningless while count is zero, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= lu_waddr;
      fifo_data_q[wr_ptr_q] <= lu_wdata;
    end
  end

endmodule
